// File: rtl/key_pkg.sv
// Shared definitions for the key encoder stage and the key code buffer.
package key_pkg;

    typedef enum logic [1:0] {IDLE, QUAL, HELD, REL} kq_state_t;

    localparam int KEY_CODE_W = 4;

endpackage

// File: rtl/sync_fifo_fwft.sv
// Small synchronous FIFO with first-word fall-through; a push into a full FIFO
// is accepted only when a pop happens in the same cycle.
module sync_fifo_fwft #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  logic [WIDTH-1:0]   push_data,
    input  logic               pop,
    output logic [WIDTH-1:0]   pop_data,
    output logic               full,
    output logic               empty,
    output logic [PTR_W:0]     level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W:0]   level_reg;
    logic             pop_fire;
    logic             push_fire;

    assign empty     = (level_reg == '0);
    assign full      = (level_reg == (PTR_W+1)'(DEPTH));
    assign pop_fire  = pop & ~empty;
    assign push_fire = push & (~full | pop_fire);
    assign level     = level_reg;
    // Head is forced to zero while empty so the output is defined after reset.
    assign pop_data  = empty ? '0 : mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (push_fire) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (push_fire) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop_fire) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({push_fire, pop_fire})
                2'b10:   level_reg <= level_reg + (PTR_W+1)'(1);
                2'b01:   level_reg <= level_reg - (PTR_W+1)'(1);
                default: level_reg <= level_reg;
            endcase
        end
    end

endmodule

// File: rtl/key_code_buffer.sv
// Qualifies encoder codes for stability, emits one code per key press into a
// FWFT FIFO, and tracks the held state and a sticky overflow flag.
module key_code_buffer
    import key_pkg::*;
#(
    parameter int CODE_W        = KEY_CODE_W,
    parameter int DEPTH         = 4,
    parameter int STABLE_CYCLES = 16,
    localparam int CNT_W = $clog2(STABLE_CYCLES + 1),
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CODE_W-1:0] code_in,
    input  logic              code_vld,
    output logic [CODE_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PTR_W:0]    fifo_level,
    output logic              key_held,
    output logic              overflow,
    input  logic              ovf_clr
);

    kq_state_t         state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next, cnt_inc;
    logic [CODE_W-1:0] cand_reg, cand_next;
    logic              overflow_reg;
    logic              match;
    logic              push;
    logic              pop;
    logic              full;
    logic              empty;

    assign match   = code_vld && (code_in == cand_reg);
    assign cnt_inc = cnt_reg + CNT_W'(1);

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        cand_next  = cand_reg;
        push       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (code_vld) begin
                    state_next = QUAL;
                    cand_next  = code_in;
                    cnt_next   = CNT_W'(1);
                end
            end
            QUAL: begin
                if (!code_vld) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (!match) begin
                    cand_next = code_in;
                    cnt_next  = CNT_W'(1);
                end else begin
                    cnt_next = cnt_inc;
                    if (cnt_inc == CNT_W'(STABLE_CYCLES)) begin
                        push       = 1'b1;
                        state_next = HELD;
                    end
                end
            end
            HELD: begin
                if (!match) begin
                    state_next = REL;
                    cnt_next   = CNT_W'(1);
                end
            end
            REL: begin
                // A return to the held code is bounce; a different valid code
                // starts a new press with the old release implied.
                if (match) begin
                    state_next = HELD;
                end else if (!code_vld) begin
                    cnt_next = cnt_inc;
                    if (cnt_inc == CNT_W'(STABLE_CYCLES)) begin
                        state_next = IDLE;
                        cnt_next   = '0;
                    end
                end else begin
                    state_next = QUAL;
                    cand_next  = code_in;
                    cnt_next   = CNT_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            cand_reg     <= '0;
            overflow_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            cand_reg  <= cand_next;
            if (push && full && !pop) begin
                overflow_reg <= 1'b1;
            end else if (ovf_clr) begin
                overflow_reg <= 1'b0;
            end
        end
    end

    assign pop       = out_valid & out_ready;
    assign out_valid = ~empty;
    assign key_held  = (state_reg == HELD) || (state_reg == REL);
    assign overflow  = overflow_reg;

    sync_fifo_fwft #(
        .WIDTH (CODE_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (cand_reg),
        .pop       (pop),
        .pop_data  (out_data),
        .full      (full),
        .empty     (empty),
        .level     (fifo_level)
    );

endmodule

// File: tb/tb_key_code_buffer.sv
// Directed bench for key_code_buffer with a queue scoreboard checked by a
// separate pop monitor.
module tb_key_code_buffer;

    localparam int W = 4;
    localparam int D = 4;
    localparam int S = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] code_in = '0;
    logic         code_vld = 1'b0;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [2:0]   fifo_level;
    logic         key_held;
    logic         overflow;
    logic         ovf_clr = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;
    logic [W-1:0] expq [$];

    key_code_buffer #(.CODE_W(W), .DEPTH(D), .STABLE_CYCLES(S)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .code_in    (code_in),
        .code_vld   (code_vld),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .fifo_level (fifo_level),
        .key_held   (key_held),
        .overflow   (overflow),
        .ovf_clr    (ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp_v);
        n_cmp++;
        if (act != exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp_v, $time);
        end else begin
            $display("ok   %s = %0d", name, act);
        end
    endtask

    // Inputs change 1 time unit after a rising edge, then n edges elapse.
    task automatic drive(input logic v, input logic [W-1:0] c, input int n);
        code_vld = v;
        code_in  = c;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [W-1:0] c, input bit accepted);
        drive(1'b1, c, S);
        if (accepted) expq.push_back(c);
        drive(1'b0, '0, S);
    endtask

    task automatic drain(input int n);
        out_ready = 1'b1;
        drive(1'b0, '0, n);
        out_ready = 1'b0;
    endtask

    // Monitor: a pop happens at the next rising edge whenever valid & ready.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            n_cmp++;
            if (expq.size() == 0) begin
                n_bad++;
                $display("FAIL pop_unexpected: got %0d expected no pop (t=%0t)", out_data, $time);
            end else begin
                logic [W-1:0] e;
                e = expq.pop_front();
                if (out_data !== e) begin
                    n_bad++;
                    $display("FAIL pop_data: got %0d expected %0d (t=%0t)", out_data, e, $time);
                end else begin
                    $display("pop  %0d", out_data);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        // 1: reset with a key present, then qualify it
        code_vld = 1'b1;
        code_in  = 4'd7;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_level", int'(fifo_level), 0);
        chk("rst_overflow", int'(overflow), 0);
        chk("rst_key_held", int'(key_held), 0);
        chk("rst_out_data", int'(out_data), 0);
        rst_n = 1'b1;
        drive(1'b1, 4'd7, S - 1);
        chk("t1_level_before", int'(fifo_level), 0);
        drive(1'b1, 4'd7, 1);
        expq.push_back(4'd7);
        chk("t1_level", int'(fifo_level), 1);
        chk("t1_key_held", int'(key_held), 1);
        chk("t1_out_data", int'(out_data), 7);
        drive(1'b0, '0, S);
        chk("t1_released", int'(key_held), 0);
        drain(2);
        chk("t1_drained", int'(fifo_level), 0);

        // 2: bounce yields a single code
        drive(1'b1, 4'd5, 2);
        drive(1'b0, '0, 1);
        drive(1'b1, 4'd5, 4);
        expq.push_back(4'd5);
        drive(1'b0, '0, 2);
        drive(1'b1, 4'd5, 3);
        chk("t2_held_mid", int'(key_held), 1);
        drive(1'b0, '0, 4);
        chk("t2_level", int'(fifo_level), 1);
        chk("t2_key_held", int'(key_held), 0);
        drain(2);

        // 3: key change without a gap; 8 needs a HELD->REL->QUAL detour
        drive(1'b1, 4'd3, 4);
        expq.push_back(4'd3);
        drive(1'b1, 4'd8, 4);
        chk("t3_level_after4", int'(fifo_level), 1);
        drive(1'b1, 4'd8, 1);
        expq.push_back(4'd8);
        chk("t3_level", int'(fifo_level), 2);
        chk("t3_head", int'(out_data), 3);
        drive(1'b0, '0, S);
        drain(3);
        chk("t3_drained", int'(fifo_level), 0);

        // 4: overflow
        press(4'd1, 1'b1);
        press(4'd2, 1'b1);
        press(4'd3, 1'b1);
        press(4'd4, 1'b1);
        chk("t4_no_ovf_yet", int'(overflow), 0);
        press(4'd6, 1'b0);
        chk("t4_level", int'(fifo_level), 4);
        chk("t4_overflow", int'(overflow), 1);
        chk("t4_head", int'(out_data), 1);
        ovf_clr = 1'b1;
        drive(1'b0, '0, 1);
        ovf_clr = 1'b0;
        chk("t4_ovf_cleared", int'(overflow), 0);

        // 5: push and pop together while full
        drive(1'b1, 4'd9, S - 1);
        out_ready = 1'b1;
        drive(1'b1, 4'd9, 1);
        out_ready = 1'b0;
        expq.push_back(4'd9);
        chk("t5_level", int'(fifo_level), 4);
        chk("t5_head", int'(out_data), 2);
        chk("t5_overflow", int'(overflow), 0);
        drive(1'b0, '0, S);
        drain(4);
        chk("t5_drained", int'(fifo_level), 0);

        // 6: backpressure
        press(4'd2, 1'b1);
        press(4'd4, 1'b1);
        out_ready = 1'b1;
        drive(1'b0, '0, 1);
        chk("t6_level_a", int'(fifo_level), 1);
        out_ready = 1'b0;
        drive(1'b0, '0, 1);
        chk("t6_level_b", int'(fifo_level), 1);
        chk("t6_head", int'(out_data), 4);
        out_ready = 1'b1;
        drive(1'b0, '0, 1);
        out_ready = 1'b0;
        chk("t6_out_valid", int'(out_valid), 0);
        out_ready = 1'b1;
        drive(1'b0, '0, 2);
        out_ready = 1'b0;
        chk("t6_empty_pop", int'(fifo_level), 0);

        // Reset mid-operation with a key held
        drive(1'b1, 4'd5, S);
        chk("t7_level", int'(fifo_level), 1);
        rst_n = 1'b0;
        #1;
        chk("t7_rst_level", int'(fifo_level), 0);
        chk("t7_rst_key_held", int'(key_held), 0);
        expq.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(1'b1, 4'd5, S - 1);
        chk("t7_requal_wait", int'(fifo_level), 0);
        drive(1'b1, 4'd5, 1);
        expq.push_back(4'd5);
        chk("t7_requal", int'(fifo_level), 1);
        drive(1'b0, '0, S);
        drain(2);

        chk("scoreboard_empty", expq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
